// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO feeding a UART transmitter through an enable/busy handshake
//
// Ports:
//   clk         rising-edge clock for all state
//   reset       synchronous, active-high
//   wr_valid    producer offers wr_data this cycle
//   wr_data     byte to enqueue
//   wr_ready    registered "not full"; a push happens when wr_valid && wr_ready
//   uart_enable one-cycle start pulse to the transmitter
//   uart_data   byte presented to the transmitter, held until the frame completes
//   uart_busy   transmitter busy indication
//   level       current occupancy, 0..DEPTH
//   overflow    sticky flag, set by any write offered while wr_ready=0

module uart_tx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_valid,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    output logic                     wr_ready,
    output logic                     uart_enable,
    output logic [DATA_WIDTH-1:0]    uart_data,
    input  logic                     uart_busy,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_ACK,
        WAIT_DONE
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  push;
    logic                  pop;
    logic [LW-1:0]         level_next;

    // wr_ready is a register, so a full FIFO rejects writes even on the
    // cycle a pop frees an entry; the freed slot is offered one cycle later.
    assign push = wr_valid && wr_ready;

    // The pop happens on the edge that enters LAUNCH, so uart_data is
    // already stable during the enable pulse.
    assign pop = (state == IDLE) && (level != '0) && !uart_busy;

    always_comb begin
        level_next = level + LW'(push) - LW'(pop);
    end

    // Storage carries no reset; occupancy is tracked by level alone.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            wr_ready    <= 1'b1;
            uart_enable <= 1'b0;
            uart_data   <= '0;
            overflow    <= 1'b0;
        end else begin
            level    <= level_next;
            wr_ready <= (level_next != FULL_LEVEL);

            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end

            if (wr_valid && !wr_ready) begin
                overflow <= 1'b1;
            end

            case (state)
                IDLE: begin
                    uart_enable <= 1'b0;
                    if (pop) begin
                        uart_data   <= mem[rd_ptr];
                        rd_ptr      <= rd_ptr + AW'(1);
                        uart_enable <= 1'b1;
                        state       <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    uart_enable <= 1'b0;
                    state       <= WAIT_ACK;
                end
                // The transmitter may take several cycles (its baud tick)
                // before it reports busy; wait for that rising edge first so
                // the falling edge below really marks the end of this frame.
                WAIT_ACK: begin
                    uart_enable <= 1'b0;
                    if (uart_busy) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    uart_enable <= 1'b0;
                    if (!uart_busy) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    uart_enable <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for uart_tx_fifo with a behavioural UART model

module tb_uart_tx_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr_valid = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ready;
    logic          uart_enable;
    logic [DW-1:0] uart_data;
    logic          uart_busy = 1'b0;
    logic [LW-1:0] level;
    logic          overflow;

    uart_tx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .uart_enable (uart_enable),
        .uart_data   (uart_data),
        .uart_busy   (uart_busy),
        .level       (level),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // reference model: byte queue in push order, occupancy, sticky overflow
    logic [DW-1:0] exp_q[$];
    int            mdl_level = 0;
    bit            mdl_ovf   = 1'b0;

    // UART model controls
    bit busy_mode   = 1'b0;
    bit busy_force  = 1'b0;
    bit rand_timing = 1'b0;
    int ack_delay   = 1;
    int frame_len   = 3;
    int acnt        = 0;
    int fcnt        = 0;
    bit pending     = 1'b0;

    // monitor state
    logic [DW-1:0] held = '0;
    bit            in_frame  = 1'b0;
    bit            seen_busy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // one clock: advance the reference model with what was offered at the edge
    task automatic step();
        int pre;
        bit acc;
        @(posedge clk);
        #1;
        if (reset) begin
            exp_q.delete();
            mdl_level = 0;
            mdl_ovf   = 1'b0;
        end else begin
            pre = mdl_level;
            acc = wr_valid && (pre != DEPTH);
            if (acc) exp_q.push_back(wr_data);
            if (wr_valid && !acc) mdl_ovf = 1'b1;
            mdl_level = pre + int'(acc) - int'(uart_enable);
        end
        check("level", 32'(level), 32'(mdl_level));
        check("wr_ready", 32'(wr_ready), 32'(mdl_level != DEPTH));
        check("overflow", 32'(overflow), 32'(mdl_ovf));
    endtask

    task automatic wait_busy(input logic val, input int limit);
        int n;
        n = 0;
        while (uart_busy !== val && n < limit) begin
            step();
            n++;
        end
        check("busy_wait", 32'(uart_busy), 32'(val));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((level !== '0 || uart_busy || in_frame || pending) && n < 3000) begin
            step();
            n++;
        end
        check("drain_level", 32'(level), 32'd0);
        check("drain_leftover", 32'(exp_q.size()), 32'd0);
    endtask

    // transmitter model: busy rises some cycles after enable, stays up for a frame
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                pending   = 1'b0;
                uart_busy = 1'b0;
            end else if (busy_mode) begin
                uart_busy = busy_force;
            end else if (uart_enable && !pending) begin
                pending = 1'b1;
                acnt    = rand_timing ? int'($urandom_range(1, 4)) : ack_delay;
                fcnt    = rand_timing ? int'($urandom_range(0, 6)) : frame_len - 1;
            end else if (pending) begin
                if (!uart_busy) begin
                    if (acnt > 1) acnt--;
                    else uart_busy = 1'b1;
                end else if (fcnt > 0) begin
                    fcnt--;
                end else begin
                    uart_busy = 1'b0;
                    pending   = 1'b0;
                end
            end else begin
                uart_busy = 1'b0;
            end
        end
    end

    // scoreboard monitor
    always @(negedge clk) begin
        if (reset) begin
            in_frame  = 1'b0;
            seen_busy = 1'b0;
        end else if (uart_enable) begin
            check("enable_during_frame", 32'(in_frame), 32'd0);
            if (exp_q.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL spurious_enable: got data %0h with no byte expected", uart_data);
            end else begin
                check("tx_data", 32'(uart_data), 32'(exp_q.pop_front()));
            end
            held      = uart_data;
            in_frame  = 1'b1;
            seen_busy = 1'b0;
        end else if (in_frame) begin
            check("data_hold", 32'(uart_data), 32'(held));
            if (uart_busy) seen_busy = 1'b1;
            else if (seen_busy) in_frame = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int nxt;
        int n;

        // reset state
        reset = 1'b1;
        repeat (3) step();
        check("rst_enable", 32'(uart_enable), 32'd0);
        check("rst_data", 32'(uart_data), 32'd0);
        reset = 1'b0;
        step();

        // single byte and handshake hold
        ack_delay = 5;
        frame_len = 100;
        wr_valid = 1'b1;
        wr_data  = 8'hA5;
        step();
        wr_valid = 1'b0;
        check("a5_no_fallthrough", 32'(uart_enable), 32'd0);
        check("a5_level1", 32'(level), 32'd1);
        step();
        check("a5_enable", 32'(uart_enable), 32'd1);
        check("a5_data", 32'(uart_data), 32'hA5);
        check("a5_level0", 32'(level), 32'd0);
        wr_valid = 1'b1;
        wr_data  = 8'h3C;
        step();
        wr_valid = 1'b0;
        wait_busy(1'b1, 20);
        wait_busy(1'b0, 200);
        step();
        check("second_gap", 32'(uart_enable), 32'd0);
        step();
        check("second_enable", 32'(uart_enable), 32'd1);
        check("second_data", 32'(uart_data), 32'h3C);
        drain();

        // full and overflow with the transmitter held busy
        busy_mode  = 1'b1;
        busy_force = 1'b1;
        step();
        for (int i = 0; i < 17; i++) begin
            wr_valid = 1'b1;
            wr_data  = DW'(i);
            step();
            if (i == 15) check("ovf_before_17th", 32'(overflow), 32'd0);
        end
        wr_valid = 1'b0;
        check("full_level", 32'(level), 32'd16);
        check("full_ready", 32'(wr_ready), 32'd0);
        check("full_overflow", 32'(overflow), 32'd1);

        // write coinciding with a pop from a full FIFO
        busy_mode = 1'b0;
        ack_delay = 2;
        frame_len = 3;
        step();
        wr_valid = 1'b1;
        wr_data  = 8'h55;
        step();
        check("sim_pop_enable", 32'(uart_enable), 32'd1);
        check("sim_reject_level", 32'(level), 32'd15);
        step();
        wr_valid = 1'b0;
        check("sim_accept_level", 32'(level), 32'd16);
        drain();

        // reset in the middle of a frame
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        ack_delay = 1;
        frame_len = 100;
        for (int i = 0; i < 6; i++) begin
            wr_valid = 1'b1;
            wr_data  = DW'($urandom);
            step();
        end
        wr_valid = 1'b0;
        wait_busy(1'b1, 20);
        step();
        step();
        check("pre_reset_level", 32'(level), 32'd5);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_level", 32'(level), 32'd0);
        check("mid_rst_ready", 32'(wr_ready), 32'd1);
        check("mid_rst_enable", 32'(uart_enable), 32'd0);
        check("mid_rst_overflow", 32'(overflow), 32'd0);
        for (int i = 0; i < 20; i++) begin
            step();
            check("no_enable_after_reset", 32'(uart_enable), 32'd0);
        end

        // wrap-around stream of 40 incrementing bytes with random handshake timing
        rand_timing = 1'b1;
        nxt = 0;
        n   = 0;
        while (nxt < 40 && n < 3000) begin
            wr_valid = ($urandom_range(0, 1) == 1);
            wr_data  = DW'(nxt);
            if (wr_valid && mdl_level != DEPTH) nxt++;
            step();
            check("level_bound", 32'(level <= LW'(DEPTH)), 32'd1);
            n++;
        end
        wr_valid = 1'b0;
        check("stream_done", 32'(nxt), 32'd40);
        drain();

        // random traffic including overflow
        for (int i = 0; i < 300; i++) begin
            wr_valid = ($urandom_range(0, 3) != 0);
            wr_data  = DW'($urandom);
            step();
        end
        wr_valid = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
